// File: rtl/wb_cmd_initiator_if.sv
// Command/response port plus Wishbone B4 classic initiator signals.
// The master modport is the initiator side; slave is the host plus bus responder.
interface wb_cmd_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel, rsp_ready,
           wb_dat_i, wb_ack_i, wb_err_i,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel, rsp_ready,
           wb_dat_i, wb_ack_i, wb_err_i,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/wb_cmd_initiator.sv
// Single-transfer Wishbone B4 classic initiator for debug/program loaders.
// One command in flight; ends with ack, err or timeout and a held response.
module wb_cmd_initiator #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TCNT_W         = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_cmd_initiator_if.master  bus
);

  // state | meaning
  // IDLE  | ready for a command, Wishbone idle
  // BUS   | cyc/stb asserted, waiting for ack/err/timeout
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam bit                TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TCNT_W-1:0] TC_LAST = TO_EN ? TCNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t            state, state_nxt;
  logic [TCNT_W-1:0] tcnt;
  logic              accept, done_err, done_ack, done_to;

  logic [31:0] adr, dat_out, rdata;
  logic        we, cyc, rvalid, rerr, rto;
  logic [3:0]  sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_err  = 1'b0;
    done_ack  = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        accept    = 1'b1;
        state_nxt = BUS;
      end
      BUS: begin
        if (bus.wb_err_i)                  done_err = 1'b1;
        else if (bus.wb_ack_i)             done_ack = 1'b1;
        else if (TO_EN && tcnt == TC_LAST) done_to  = 1'b1;
        if (bus.wb_err_i || bus.wb_ack_i || done_to) state_nxt = RESP;
      end
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      adr     <= '0;
      dat_out <= '0;
      we      <= 1'b0;
      sel     <= '0;
      cyc     <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rerr    <= 1'b0;
      rto     <= 1'b0;
    end else begin
      if (accept) begin
        adr     <= bus.cmd_addr;
        dat_out <= bus.cmd_wdata;
        we      <= bus.cmd_we;
        sel     <= bus.cmd_sel;
        cyc     <= 1'b1;
        tcnt    <= '0;
      end
      if (state == BUS) tcnt <= tcnt + TCNT_W'(1);
      if (done_err || done_ack || done_to) begin
        cyc    <= 1'b0;
        rvalid <= 1'b1;
        rerr   <= done_err || done_to;
        rto    <= done_to;
        // read data is captured only on a clean ack of a read
        rdata  <= (done_ack && !we) ? bus.wb_dat_i : 32'h0;
      end
      if (state == RESP && bus.rsp_ready) rvalid <= 1'b0;
    end
  end

  assign bus.cmd_ready   = rst_n && (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.wb_adr_o    = adr;
  assign bus.wb_dat_o    = dat_out;
  assign bus.wb_we_o     = we;
  assign bus.wb_sel_o    = sel;
  assign bus.wb_cyc_o    = cyc;
  assign bus.wb_stb_o    = cyc;
  assign bus.rsp_valid   = rvalid;
  assign bus.rsp_rdata   = rdata;
  assign bus.rsp_err     = rerr;
  assign bus.rsp_timeout = rto;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator: vector table plus reset/hold/back-to-back sequences.
// Responder is a 256-word memory that acks one cycle after stb, optionally with err or silent.
module tb_wb_cmd_initiator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_cmd_initiator_if bus();

  wb_cmd_initiator #(.TIMEOUT_CYCLES(8), .TCNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // responder mode: 0 = ack, 1 = ack+err, 2 = silent
  int          resp_mode = 0;
  logic        ack_r, err_r;
  logic [31:0] mem [0:255];
  logic        hit;

  assign hit          = bus.wb_cyc_o && bus.wb_stb_o && !ack_r && !err_r;
  assign bus.wb_ack_i = ack_r;
  assign bus.wb_err_i = err_r;
  assign bus.wb_dat_i = mem[bus.wb_adr_o[9:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else begin
      ack_r <= hit && (resp_mode != 2);
      err_r <= hit && (resp_mode == 1);
      if (hit && resp_mode == 0 && bus.wb_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.wb_sel_o[b]) mem[bus.wb_adr_o[9:2]][b*8 +: 8] <= bus.wb_dat_o[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          mode;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[9];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur     = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, cur, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sel);
    @(negedge clk);
    check("cmd_ready_idle", bus.cmd_ready, 1'b1);
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_sel   = sel;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // starts on the first negedge after the accepting edge
  task automatic wait_rsp(output int cyc_cnt, output int edges, output logic stb_ok,
                          output logic [31:0] adr_seen, output logic we_seen);
    cyc_cnt  = 0;
    edges    = 0;
    stb_ok   = 1'b1;
    adr_seen = 32'h0;
    we_seen  = 1'b0;
    while (!bus.rsp_valid && edges < 40) begin
      if (bus.wb_stb_o !== bus.wb_cyc_o) stb_ok = 1'b0;
      if (bus.wb_cyc_o) begin
        cyc_cnt++;
        adr_seen = bus.wb_adr_o;
        we_seen  = bus.wb_we_o;
      end
      @(negedge clk);
      edges++;
    end
    check("rsp_valid_seen", bus.rsp_valid, 1'b1);
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_valid_clear", bus.rsp_valid, 1'b0);
    check("cmd_ready_back", bus.cmd_ready, 1'b1);
  endtask

  initial begin
    int          cyc_cnt, edges, n_acc, a0, a1;
    logic        stb_ok, we_seen, stray;
    logic [31:0] adr_seen;

    //           we    addr          wdata         sel    mode  rdata         err   to    cyc
    vecs[0] = '{1'b1, 32'h100, 32'hDEADBEEF, 4'hF,    0, 32'h0,        1'b0, 1'b0, 2};
    vecs[1] = '{1'b0, 32'h100, 32'h0,        4'hF,    0, 32'hDEADBEEF, 1'b0, 1'b0, 2};
    vecs[2] = '{1'b1, 32'h100, 32'h0000AB00, 4'b0010, 0, 32'h0,        1'b0, 1'b0, 2};
    vecs[3] = '{1'b0, 32'h100, 32'h0,        4'hF,    0, 32'hDEADABEF, 1'b0, 1'b0, 2};
    vecs[4] = '{1'b0, 32'h100, 32'h0,        4'hF,    1, 32'h0,        1'b1, 1'b0, 2};
    vecs[5] = '{1'b1, 32'h200, 32'h55AA55AA, 4'hF,    1, 32'h0,        1'b1, 1'b0, 2};
    vecs[6] = '{1'b0, 32'h104, 32'h0,        4'hF,    2, 32'h0,        1'b1, 1'b1, 8};
    vecs[7] = '{1'b1, 32'h104, 32'h12345678, 4'b1100, 0, 32'h0,        1'b0, 1'b0, 2};
    vecs[8] = '{1'b0, 32'h104, 32'h0,        4'hF,    0, 32'h12340000, 1'b0, 1'b0, 2};

    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_sel   = 4'h0;
    bus.rsp_ready = 1'b0;

    #12;
    check("rst_cyc", bus.wb_cyc_o, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);

    for (int i = 0; i < 9; i++) begin
      cur       = i;
      resp_mode = vecs[i].mode;
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel);
      check("busy_in_bus", bus.busy, 1'b1);
      wait_rsp(cyc_cnt, edges, stb_ok, adr_seen, we_seen);
      check("cyc_cycles", cyc_cnt, vecs[i].exp_cyc);
      check("rsp_latency", edges, vecs[i].exp_cyc);
      check("stb_eq_cyc", stb_ok, 1'b1);
      check("wb_adr", adr_seen, vecs[i].addr);
      check("wb_we", we_seen, vecs[i].we);
      check("cyc_low_in_resp", bus.wb_cyc_o, 1'b0);
      check("rsp_rdata", bus.rsp_rdata, vecs[i].exp_rdata);
      check("rsp_err", bus.rsp_err, vecs[i].exp_err);
      check("rsp_timeout", bus.rsp_timeout, vecs[i].exp_to);
      consume();
    end
    cur = 100;
    check("mem_word64", mem[64], 32'hDEADABEF);
    check("mem_word65", mem[65], 32'h12340000);

    // response held while rsp_ready stays low
    cur       = 101;
    resp_mode = 0;
    issue(1'b0, 32'h100, 32'h0, 4'hF);
    wait_rsp(cyc_cnt, edges, stb_ok, adr_seen, we_seen);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", bus.rsp_valid, 1'b1);
      check("hold_rdata", bus.rsp_rdata, 32'hDEADABEF);
      check("hold_err", bus.rsp_err, 1'b0);
      check("hold_cmd_ready", bus.cmd_ready, 1'b0);
      check("hold_cyc", bus.wb_cyc_o, 1'b0);
    end
    consume();

    // back-to-back with rsp_ready tied high: one accept every 4 cycles
    cur = 102;
    @(negedge clk);
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 32'h100;
    bus.cmd_sel   = 4'hF;
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    n_acc = 0;
    a0 = -1;
    a1 = -1;
    for (int i = 0; i < 8; i++) begin
      if (bus.cmd_ready) begin
        if (n_acc == 0) a0 = i;
        else            a1 = i;
        n_acc++;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("b2b_accepts", n_acc, 2);
    check("b2b_spacing", a1 - a0, 4);
    check("b2b_idle_end", bus.cmd_ready, 1'b1);
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // reset during BUS drops cyc at once and loses the transfer
    cur = 103;
    issue(1'b0, 32'h100, 32'h0, 4'hF);
    check("pre_rst_cyc", bus.wb_cyc_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_cyc", bus.wb_cyc_o, 1'b0);
    check("rst_mid_stb", bus.wb_stb_o, 1'b0);
    check("rst_mid_busy", bus.busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.wb_cyc_o) stray = 1'b1;
    end
    check("no_rsp_after_rst", stray, 1'b0);
    check("idle_after_rst", bus.cmd_ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, step %0d", cur);
    $fatal(1, "watchdog expired");
  end

endmodule
